// File: rtl/axis_perf_pkg.sv
// Shared definitions for the AXI-Stream performance packet generator and the
// matching receive-side checker.
//   state_t        : generator FSM states
//   SEQ_OFF/SIZE_OFF : byte offsets of the header fields in beat 0
//   BYTES_PER_BEAT : bytes per 512-bit beat
//   LFSR_SEED/POLY : payload LFSR seed and Galois tap mask (right-shifting)
//   last_keep()    : tkeep of the final beat for a given packet size
package axis_perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int SEQ_OFF        = 0;
    localparam int SIZE_OFF       = 4;
    localparam int BYTES_PER_BEAT = 64;

    // x^32 + x^22 + x^2 + x + 1, taps at bits 31, 21, 1, 0 for a right shift.
    localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Low R bytes set, R = size mod 64 (a zero remainder means a full beat).
    function automatic logic [BYTES_PER_BEAT-1:0] last_keep(input logic [15:0] size);
        logic [6:0] r;
        r = {1'b0, size[5:0]};
        if (r == 7'd0) begin
            r = 7'd64;
        end
        last_keep = '0;
        for (int i = 0; i < BYTES_PER_BEAT; i++) begin
            if (i < int'(r)) begin
                last_keep[i] = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/axis_perf_lfsr32.sv
// 32-bit Galois LFSR used as the optional payload source.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   enable     : advance one step
//   load       : reseed to LFSR_SEED (takes priority over enable)
//   value      : current LFSR state
module axis_perf_lfsr32
    import axis_perf_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        enable,
    input  logic        load,
    output logic [31:0] value
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            value <= LFSR_SEED;
        end else if (load) begin
            value <= LFSR_SEED;
        end else if (enable) begin
            value <= (value >> 1) ^ (value[0] ? LFSR_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/axis_perf_pkt_gen.sv
// Transmit-side AXI-Stream traffic generator. Emits numbered packets of a
// programmable size, inter-packet gap and count, and keeps TX performance
// counters.
// Ports:
//   CLK, RST_N          : clock, asynchronous active-low reset
//   start, stop         : single-cycle control pulses
//   pkt_size            : packet bytes (latched at start)
//   pkt_interval        : idle cycles between packets (latched at start)
//   pkt_num             : packet count, 0 = unlimited (latched at start)
//   m_axis_*            : AXI-Stream master
//   busy                : FSM not idle
//   send_pkt_cnt        : completed packets
//   beat_cnt            : accepted beats
//   cycle_cnt(_full)    : busy cycles, saturating, with sticky full flag
// Optional feature: define AXIS_PERF_PKT_GEN_LFSR_PAYLOAD_EN to take the
// non-header payload bytes from a 32-bit LFSR instead of the counting pattern.
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high; while tvalid is high and tready low the beat is held unchanged,
// and tvalid only drops after a tlast transfer (or on reset).
module axis_perf_pkt_gen
    import axis_perf_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic                  stop,
    input  logic [15:0]           pkt_size,
    input  logic [CNT_WIDTH-1:0]  pkt_interval,
    input  logic [CNT_WIDTH-1:0]  pkt_num,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  send_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  beat_cnt,
    output logic [CNT_WIDTH-1:0]  cycle_cnt,
    output logic                  cycle_cnt_full
);

    state_t               state;
    state_t               state_next;
    logic [15:0]          cfg_size;
    logic [CNT_WIDTH-1:0] cfg_interval;
    logic [CNT_WIDTH-1:0] cfg_num;
    logic [31:0]          seq;
    logic [15:0]          beat_idx;
    logic [CNT_WIDTH-1:0] gap_cnt;
    logic                 stop_pending;

    logic                 start_ok;
    logic                 hs;
    logic                 hs_last;
    logic                 last_beat;
    logic                 limit_hit;
    logic [16:0]          num_beats;
    logic [7:0]           fill_byte;

    assign start_ok  = (state == IDLE) && start && (pkt_size != 16'd0);
    assign hs        = m_axis_tvalid && m_axis_tready;
    assign num_beats = ({1'b0, cfg_size} + 17'd63) >> 6;
    assign last_beat = ({1'b0, beat_idx} == (num_beats - 17'd1));
    assign hs_last   = hs && last_beat;
    assign limit_hit = (cfg_num != '0) && ((send_pkt_cnt + 1'b1) == cfg_num);

`ifdef AXIS_PERF_PKT_GEN_LFSR_PAYLOAD_EN
    logic [31:0] lfsr_value;
    logic [31:0] lane;

    axis_perf_lfsr32 u_lfsr (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .enable (hs),
        .load   (start_ok),
        .value  (lfsr_value)
    );
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (hs_last) begin
                    // A stop arriving on the tlast cycle itself also ends the run.
                    if (limit_hit || stop_pending || stop) begin
                        state_next = IDLE;
                    end else if (cfg_interval != '0) begin
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (gap_cnt == CNT_WIDTH'(1)) begin
                    state_next = SEND;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tkeep  = '0;
        busy          = 1'b0;
        case (state)
            SEND: begin
                busy          = 1'b1;
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = last_beat;
                m_axis_tkeep  = last_beat ? KEEP_WIDTH'(last_keep(cfg_size)) : '1;
            end
            GAP: begin
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign m_axis_tuser = '0;

    // Payload: header in beat 0, then the fill pattern; bytes outside tkeep
    // are forced to zero (which also zeroes tdata outside SEND).
    always_comb begin
        m_axis_tdata = '0;
        fill_byte    = '0;
`ifdef AXIS_PERF_PKT_GEN_LFSR_PAYLOAD_EN
        lane         = '0;
`endif
        for (int k = 0; k < KEEP_WIDTH; k++) begin
`ifdef AXIS_PERF_PKT_GEN_LFSR_PAYLOAD_EN
            lane      = lfsr_value ^ 32'(k / 4);
            fill_byte = 8'(lane >> (8 * (k % 4)));
`else
            fill_byte = 8'(32'(beat_idx) * BYTES_PER_BEAT + k);
`endif
            if (beat_idx == 16'd0) begin
                case (k)
                    SEQ_OFF + 0:  fill_byte = seq[7:0];
                    SEQ_OFF + 1:  fill_byte = seq[15:8];
                    SEQ_OFF + 2:  fill_byte = seq[23:16];
                    SEQ_OFF + 3:  fill_byte = seq[31:24];
                    SIZE_OFF + 0: fill_byte = cfg_size[7:0];
                    SIZE_OFF + 1: fill_byte = cfg_size[15:8];
                    default: ;
                endcase
            end
            if (m_axis_tkeep[k]) begin
                m_axis_tdata[8*k +: 8] = fill_byte;
            end
        end
    end

    // ---------------- Datapath and counters ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cfg_size       <= '0;
            cfg_interval   <= '0;
            cfg_num        <= '0;
            seq            <= '0;
            beat_idx       <= '0;
            gap_cnt        <= '0;
            stop_pending   <= 1'b0;
            send_pkt_cnt   <= '0;
            beat_cnt       <= '0;
            cycle_cnt      <= '0;
            cycle_cnt_full <= 1'b0;
        end else if (start_ok) begin
            cfg_size       <= pkt_size;
            cfg_interval   <= pkt_interval;
            cfg_num        <= pkt_num;
            seq            <= '0;
            beat_idx       <= '0;
            gap_cnt        <= '0;
            stop_pending   <= 1'b0;
            send_pkt_cnt   <= '0;
            beat_cnt       <= '0;
            cycle_cnt      <= '0;
            cycle_cnt_full <= 1'b0;
        end else begin
            if (busy && (cycle_cnt != '1)) begin
                cycle_cnt <= cycle_cnt + 1'b1;
                if ((cycle_cnt + 1'b1) == '1) begin
                    cycle_cnt_full <= 1'b1;
                end
            end

            if (hs) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (last_beat) begin
                    beat_idx     <= '0;
                    send_pkt_cnt <= send_pkt_cnt + 1'b1;
                    seq          <= seq + 32'd1;
                end else begin
                    beat_idx <= beat_idx + 16'd1;
                end
            end

            if ((state == SEND) && (state_next == GAP)) begin
                gap_cnt <= cfg_interval;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            if (state_next == IDLE) begin
                stop_pending <= 1'b0;
            end else if ((state == SEND) && stop) begin
                stop_pending <= 1'b1;
            end
        end
    end

endmodule
